// File: rtl/blink_sequencer.sv
// Blink sequencer: drives an LED through a per-mode on/off pattern
// for a set number of blinks, or continuously until aborted.
module blink_sequencer #(
  parameter int NUM_MODES = 2,
  parameter int MODE_W    = 1,
  parameter int TIMER_W   = 32,
  parameter int COUNT_W   = 4,
  parameter logic [NUM_MODES*TIMER_W-1:0] ON_TICKS =
    {32'd2400000, 32'd6000000},
  parameter logic [NUM_MODES*TIMER_W-1:0] OFF_TICKS =
    {32'd2400000, 32'd12000000},
  parameter logic [NUM_MODES*COUNT_W-1:0] BLINKS =
    {4'd5, 4'd3},
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic               hwclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MODE_W-1:0]  mode,
  input  logic               abort,
  output logic               led,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] blink_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [TIMER_W-1:0] on_q, on_d;
  logic [TIMER_W-1:0] off_q, off_d;
  logic [COUNT_W-1:0] bl_q, bl_d;
  logic               done_q, done_d;
  logic               abrt_q, abrt_d;

  logic               sel_ok;
  logic [TIMER_W-1:0] sel_on;
  logic [TIMER_W-1:0] sel_off;
  logic [COUNT_W-1:0] sel_bl;

  logic [TIMER_W-1:0] on_last;
  logic [TIMER_W-1:0] off_last;
  logic [COUNT_W-1:0] idx_inc;
  logic               on_end;
  logic               off_end;
  logic               seq_end;

  // Look up the requested mode's pattern; out-of-range modes never match.
  always_comb begin
    sel_ok  = 1'b0;
    sel_on  = '0;
    sel_off = '0;
    sel_bl  = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode == MODE_W'(m)) begin
        sel_ok  = 1'b1;
        sel_on  = ON_TICKS[m*TIMER_W +: TIMER_W];
        sel_off = OFF_TICKS[m*TIMER_W +: TIMER_W];
        sel_bl  = BLINKS[m*COUNT_W +: COUNT_W];
      end
    end
  end

  // A zero period behaves as one cycle, so the timer never wraps.
  assign on_last  = (on_q == '0) ? '0 : on_q - TIMER_W'(1);
  assign off_last = (off_q == '0) ? '0 : off_q - TIMER_W'(1);
  assign on_end   = (timer_q == on_last);
  assign off_end  = (timer_q == off_last);
  assign idx_inc  = idx_q + COUNT_W'(1);
  assign seq_end  = (bl_q != '0) && (idx_inc == bl_q);

  // Next-state, timer, blink count and pulse generation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    on_d    = on_q;
    off_d   = off_q;
    bl_d    = bl_q;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort && sel_ok) begin
          state_d = S_ON;
          timer_d = '0;
          idx_d   = '0;
          on_d    = sel_on;
          off_d   = sel_off;
          bl_d    = sel_bl;
        end
      end
      S_ON: begin
        if (abort) begin
          state_d = S_IDLE;
          timer_d = '0;
          abrt_d  = 1'b1;
        end else if (on_end) begin
          state_d = S_OFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_OFF: begin
        if (abort) begin
          state_d = S_IDLE;
          timer_d = '0;
          abrt_d  = 1'b1;
        end else if (off_end) begin
          timer_d = '0;
          idx_d   = idx_inc;
          if (seq_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ON;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      bl_q    <= '0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      off_q   <= off_d;
      bl_q    <= bl_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  assign led       = (state_q == S_ON) ^ LED_ACTIVE_LOW;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign aborted   = abrt_q;
  assign blink_idx = idx_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer: a cycle-count reference model
// predicts outputs per cycle; a monitor pops and compares them.
module tb_blink_sequencer;

  logic       hwclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [0:0] mode;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] blink_idx;

  int checks = 0;
  int errors = 0;

  blink_sequencer #(
    .NUM_MODES(2),
    .MODE_W(1),
    .TIMER_W(32),
    .COUNT_W(4),
    .ON_TICKS({32'd3, 32'd2}),
    .OFF_TICKS({32'd1, 32'd3}),
    .BLINKS({4'd0, 4'd2}),
    .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .hwclk(hwclk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .abort(abort),
    .led(led),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .blink_idx(blink_idx)
  );

  always #5 hwclk = ~hwclk;

  typedef struct {
    logic       led;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] idx;
  } exp_t;

  exp_t sbq[$];

  int on_t[2]  = '{2, 3};
  int off_t[2] = '{3, 1};
  int bl_t[2]  = '{2, 0};

  bit run;
  int m;
  int t;
  int idx;
  bit dn;
  bit ab;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference model: position t cycles into a run; each blink is on+off
  // cycles long, so led and count follow from t by division.
  always @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0; t = 0; idx = 0; dn = 0; ab = 0;
      sbq.delete();
    end else begin
      exp_t e;
      int p;
      dn = 0;
      ab = 0;
      if (!run) begin
        if (start && !abort && int'(mode) < 2) begin
          run = 1; m = int'(mode); t = 0; idx = 0;
        end
      end else if (abort) begin
        run = 0;
        ab  = 1;
      end else begin
        t++;
        p = on_t[m] + off_t[m];
        if (t % p == 0) idx = (t / p) % 16;
        if (bl_t[m] != 0 && t / p == bl_t[m]) begin
          run = 0;
          dn  = 1;
        end
      end
      p = on_t[m] + off_t[m];
      e.led     = run && ((t % p) < on_t[m]);
      e.busy    = run;
      e.done    = dn;
      e.aborted = ab;
      e.idx     = 4'(idx);
      sbq.push_back(e);
    end
  end

  // Monitor: compare each predicted cycle against the DUT mid-cycle.
  always @(negedge hwclk) begin
    if (rst_n && sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("led", int'(led), int'(e.led));
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("aborted", int'(aborted), int'(e.aborted));
      chk("blink_idx", int'(blink_idx), int'(e.idx));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge hwclk);
  endtask

  task automatic pulse_start(input logic [0:0] md);
    start = 1'b1;
    mode  = md;
    @(negedge hwclk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    abort = 1'b0;
    cyc(3);
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_idx", int'(blink_idx), 0);
    rst_n = 1'b1;

    // mode0: two 2-on/3-off blinks then done
    pulse_start(1'b0);
    cyc(14);

    // mode1 continuous for 40 cycles, then abort
    pulse_start(1'b1);
    cyc(39);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(4);

    // starts and mode changes mid-run are ignored
    pulse_start(1'b0);
    cyc(2);
    pulse_start(1'b1);
    mode = 1'b1;
    cyc(3);
    pulse_start(1'b1);
    cyc(8);

    // start with abort in idle does nothing
    start = 1'b1;
    abort = 1'b1;
    cyc(1);
    start = 1'b0;
    abort = 1'b0;
    cyc(3);

    // start on the done cycle
    pulse_start(1'b0);
    cyc(10);
    pulse_start(1'b0);
    cyc(13);

    // abort on the final OFF cycle
    pulse_start(1'b0);
    cyc(9);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(3);

    // async reset during ON of the second blink
    pulse_start(1'b0);
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", int'(led), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_idx", int'(blink_idx), 0);
    chk("arst_done", int'(done), 0);
    cyc(2);
    rst_n = 1'b1;
    pulse_start(1'b0);
    cyc(14);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 5) == 0);
      mode  = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 29) == 0);
      @(negedge hwclk);
    end
    start = 1'b0;
    abort = 1'b0;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
